caster_scheduler: RTL and testbench

//  Sequences one MultiCaster (ifmap/fltr/psum casters) through a convolution job. Per job: load filter once,

---
 rtl/caster_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_caster_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/caster_scheduler.sv
// Sequences one MultiCaster through a job: filter once, then per pass ifmap, psum, compute, drain.
// Loads stall on buf_valid/caster_ready, drain stalls on psum_wr_ready; compute is watchdog-bounded.
module caster_scheduler #(
  parameter int NUM_COL   = 4,
  parameter int LEN_W     = 8,
  parameter int TIMEOUT_W = 12
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_fltr_len,
  input  logic [LEN_W-1:0]     cfg_ifmap_len,
  input  logic [LEN_W-1:0]     cfg_num_pass,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic [2:0]           buf_valid,
  output logic [2:0]           buf_pop,
  output logic [2:0]           caster_en,
  input  logic                 caster_ready,
  input  logic                 caster_valid,
  input  logic                 psum_wr_ready,
  output logic                 psum_wr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic [LEN_W-1:0]     pass_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_FLTR, S_LD_IFMAP, S_LD_PSUM, S_COMPUTE, S_DRAIN, S_FIN
  } state_t;

  localparam logic [LEN_W-1:0] LAST_COL = LEN_W'(NUM_COL - 1);

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     fltr_len_q, fltr_len_d;
  logic [LEN_W-1:0]     ifmap_len_q, ifmap_len_d;
  logic [LEN_W-1:0]     num_pass_q, num_pass_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [LEN_W-1:0]     word_cnt_q, word_cnt_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [LEN_W-1:0]     pass_idx_q, pass_idx_d;
  logic [2:0]           caster_en_q, caster_en_d;
  logic                 err_q, err_d;
  logic                 xfer;
  logic [TIMEOUT_W:0]   wdog_inc;

  // Pass 0 has no psum to fetch: partial sums start from zero inside the PEs.
  function automatic state_t ifmap_entry(input logic [LEN_W-1:0] ilen, input logic first_pass);
    if (ilen != '0)     return S_LD_IFMAP;
    else if (first_pass) return S_COMPUTE;
    else                return S_LD_PSUM;
  endfunction

  always_comb begin
    state_d     = state_q;
    fltr_len_d  = fltr_len_q;
    ifmap_len_d = ifmap_len_q;
    num_pass_d  = num_pass_q;
    timeout_d   = timeout_q;
    word_cnt_d  = word_cnt_q;
    wdog_d      = '0;
    pass_idx_d  = pass_idx_q;
    err_d       = err_q;
    buf_pop     = 3'b000;
    psum_wr_en  = 1'b0;
    xfer        = 1'b0;
    wdog_inc    = {1'b0, wdog_q} + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          fltr_len_d  = cfg_fltr_len;
          ifmap_len_d = cfg_ifmap_len;
          num_pass_d  = (cfg_num_pass == '0) ? LEN_W'(1) : cfg_num_pass;
          timeout_d   = cfg_timeout;
          err_d       = 1'b0;
          pass_idx_d  = '0;
          word_cnt_d  = '0;
          state_d     = (cfg_fltr_len != '0) ? S_LD_FLTR : ifmap_entry(cfg_ifmap_len, 1'b1);
        end
      end
      S_LD_FLTR: begin
        xfer       = caster_en_q[1] & buf_valid[1] & caster_ready;
        buf_pop[1] = xfer;
        if (xfer) begin
          if (word_cnt_q == fltr_len_q - 1'b1) begin
            word_cnt_d = '0;
            state_d    = ifmap_entry(ifmap_len_q, pass_idx_q == '0);
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      S_LD_IFMAP: begin
        xfer       = caster_en_q[0] & buf_valid[0] & caster_ready;
        buf_pop[0] = xfer;
        if (xfer) begin
          if (word_cnt_q == ifmap_len_q - 1'b1) begin
            word_cnt_d = '0;
            state_d    = (pass_idx_q == '0) ? S_COMPUTE : S_LD_PSUM;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      S_LD_PSUM: begin
        xfer       = caster_en_q[2] & buf_valid[2] & caster_ready;
        buf_pop[2] = xfer;
        if (xfer) begin
          if (word_cnt_q == LAST_COL) begin
            word_cnt_d = '0;
            state_d    = S_COMPUTE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        // A result arriving on the expiry cycle is still taken.
        if (caster_valid) begin
          word_cnt_d = '0;
          state_d    = S_DRAIN;
        end else if (wdog_inc >= {1'b0, timeout_q}) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          wdog_d = wdog_inc[TIMEOUT_W-1:0];
        end
      end
      S_DRAIN: begin
        psum_wr_en = caster_en_q[2] & psum_wr_ready;
        if (psum_wr_en) begin
          if (word_cnt_q == LAST_COL) begin
            word_cnt_d = '0;
            if (pass_idx_q == num_pass_q - 1'b1) begin
              state_d = S_FIN;
            end else begin
              pass_idx_d = pass_idx_q + 1'b1;
              state_d    = ifmap_entry(ifmap_len_q, 1'b0);
            end
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Enables are registered off the next state so they are live from the first cycle in state.
    case (state_d)
      S_LD_FLTR:          caster_en_d = 3'b010;
      S_LD_IFMAP:         caster_en_d = 3'b001;
      S_LD_PSUM, S_DRAIN: caster_en_d = 3'b100;
      default:            caster_en_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      fltr_len_q  <= '0;
      ifmap_len_q <= '0;
      num_pass_q  <= '0;
      timeout_q   <= '0;
      word_cnt_q  <= '0;
      wdog_q      <= '0;
      pass_idx_q  <= '0;
      caster_en_q <= 3'b000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fltr_len_q  <= fltr_len_d;
      ifmap_len_q <= ifmap_len_d;
      num_pass_q  <= num_pass_d;
      timeout_q   <= timeout_d;
      word_cnt_q  <= word_cnt_d;
      wdog_q      <= wdog_d;
      pass_idx_q  <= pass_idx_d;
      caster_en_q <= caster_en_d;
      err_q       <= err_d;
    end
  end

  assign caster_en   = caster_en_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign err_timeout = err_q;
  assign pass_idx    = pass_idx_q;

endmodule

// File: tb/tb_caster_scheduler.sv
// Directed bench for caster_scheduler: reset, nominal, multi-pass, stalls, watchdog and edge configurations.
module tb_caster_scheduler;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_fltr_len = '0, cfg_ifmap_len = '0, cfg_num_pass = '0;
  logic [11:0] cfg_timeout = '0;
  logic [2:0]  buf_valid = 3'b111;
  logic [2:0]  buf_pop, caster_en;
  logic        caster_ready = 1'b1, caster_valid = 1'b0, psum_wr_ready = 1'b1;
  logic        psum_wr_en, busy, done, err_timeout;
  logic [7:0]  pass_idx;

  caster_scheduler #(.NUM_COL(4), .LEN_W(8), .TIMEOUT_W(12)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_fltr_len(cfg_fltr_len), .cfg_ifmap_len(cfg_ifmap_len),
    .cfg_num_pass(cfg_num_pass), .cfg_timeout(cfg_timeout),
    .buf_valid(buf_valid), .buf_pop(buf_pop), .caster_en(caster_en),
    .caster_ready(caster_ready), .caster_valid(caster_valid),
    .psum_wr_ready(psum_wr_ready), .psum_wr_en(psum_wr_en),
    .busy(busy), .done(done), .err_timeout(err_timeout), .pass_idx(pass_idx)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int vdelay = 0, comp_run = 0;
  bit stall_en = 1'b0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int n_pop_i, n_pop_f, n_pop_p, n_wr, n_done, n_comp, n_multi_en, n_bad;
  logic [7:0] pass_seen;

  // Environment: stall generator and compute responder, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (stall_en) begin
      buf_valid     = 3'($urandom_range(0, 7));
      caster_ready  = ($urandom_range(0, 3) != 0);
      psum_wr_ready = ($urandom_range(0, 2) != 0);
    end else begin
      buf_valid     = 3'b111;
      caster_ready  = 1'b1;
      psum_wr_ready = 1'b1;
    end
    if (busy && caster_en == 3'b000 && !done) comp_run = comp_run + 1;
    else comp_run = 0;
    caster_valid = (vdelay != 0) && (comp_run == vdelay);
  end

  always @(negedge clk) begin
    if (rstn) begin
      cyc = cyc + 1;
      if (buf_pop[0]) n_pop_i++;
      if (buf_pop[1]) n_pop_f++;
      if (buf_pop[2]) n_pop_p++;
      if (psum_wr_en) n_wr++;
      if ($countones(caster_en) > 1) n_multi_en++;
      for (int i = 0; i < 3; i++)
        if (buf_pop[i] && !(caster_en[i] && buf_valid[i] && caster_ready)) n_bad++;
      if (psum_wr_en && !psum_wr_ready) n_bad++;
      if (busy && caster_en == 3'b000 && !done) n_comp++;
      if (busy) pass_seen[pass_idx[2:0]] = 1'b1;
      if (start && !busy) start_cyc = cyc;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_counts();
    n_pop_i = 0; n_pop_f = 0; n_pop_p = 0; n_wr = 0; n_done = 0;
    n_comp = 0; n_multi_en = 0; n_bad = 0; pass_seen = '0;
  endtask

  // Launches one job and returns after its done cycle (or after the cycle budget runs out).
  task automatic run_job(input int fl, input int il, input int np, input int to, input int vd,
                         input bit stall, input bit hold, output int latency);
    bit got = 1'b0;
    clear_counts();
    cfg_fltr_len = 8'(fl); cfg_ifmap_len = 8'(il); cfg_num_pass = 8'(np);
    cfg_timeout = 12'(to); vdelay = vd; stall_en = stall;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL job_done_wait: done=0 after 3000 cycles, required done=1");
    end
    @(posedge clk); #1;
    stall_en = 1'b0;
    latency = done_cyc - start_cyc + 1;
  endtask

  task automatic test_reset();
    bit got = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (caster_en !== 3'b000) begin fails++; $display("FAIL rst_caster_en: got %b want 000", caster_en); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
    tests++; if (err_timeout !== 1'b0 || pass_idx !== 8'd0) begin fails++; $display("FAIL rst_err_pass: got %b/%0d want 0/0", err_timeout, pass_idx); end
    rstn = 1'b1;
    @(posedge clk); #1;
    cfg_fltr_len = 8'd2; cfg_ifmap_len = 8'd8; cfg_num_pass = 8'd1; cfg_timeout = 12'd100; vdelay = 5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (caster_en[0]) got = 1'b1;
    end
    tests++; if (!got) begin fails++; $display("FAIL rst_reach_ifmap: caster_en[0] never rose, required 1"); end
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    tests++; if (caster_en !== 3'b000 || buf_pop !== 3'b000) begin fails++; $display("FAIL rst_mid_ifmap_en_pop: got en=%b pop=%b want 000/000", caster_en, buf_pop); end
    tests++; if (busy !== 1'b0 || pass_idx !== 8'd0) begin fails++; $display("FAIL rst_mid_ifmap_busy: got busy=%b pass=%0d want 0/0", busy, pass_idx); end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_stays_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_nominal();
    int lat;
    run_job(9, 12, 1, 200, 5, 1'b0, 1'b0, lat);
    tests++; if (n_pop_f !== 9 || n_pop_i !== 12 || n_pop_p !== 0) begin fails++; $display("FAIL nom_pops: got f=%0d i=%0d p=%0d want 9/12/0", n_pop_f, n_pop_i, n_pop_p); end
    tests++; if (n_wr !== 4) begin fails++; $display("FAIL nom_wr: got %0d want 4", n_wr); end
    tests++; if (n_done !== 1) begin fails++; $display("FAIL nom_done: got %0d pulses want 1", n_done); end
    tests++; if (lat !== 32) begin fails++; $display("FAIL nom_latency: got %0d want 32", lat); end
    tests++; if (err_timeout !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL nom_end_state: got err=%b busy=%b want 0/0", err_timeout, busy); end
  endtask

  task automatic test_multi_pass();
    int lat;
    run_job(9, 12, 3, 200, 5, 1'b0, 1'b0, lat);
    tests++; if (n_pop_f !== 9 || n_pop_i !== 36 || n_pop_p !== 8) begin fails++; $display("FAIL mp_pops: got f=%0d i=%0d p=%0d want 9/36/8", n_pop_f, n_pop_i, n_pop_p); end
    tests++; if (n_wr !== 12) begin fails++; $display("FAIL mp_wr: got %0d want 12", n_wr); end
    tests++; if (pass_seen !== 8'b0000_0111) begin fails++; $display("FAIL mp_pass_idx: got seen=%b want 00000111", pass_seen); end
    tests++; if (lat !== 82 || n_done !== 1) begin fails++; $display("FAIL mp_latency: got lat=%0d done=%0d want 82/1", lat, n_done); end
  endtask

  task automatic test_stalls();
    int lat;
    run_job(9, 12, 1, 200, 5, 1'b1, 1'b0, lat);
    tests++; if (n_pop_f !== 9 || n_pop_i !== 12 || n_pop_p !== 0) begin fails++; $display("FAIL st_pops: got f=%0d i=%0d p=%0d want 9/12/0", n_pop_f, n_pop_i, n_pop_p); end
    tests++; if (n_wr !== 4 || n_done !== 1) begin fails++; $display("FAIL st_wr_done: got wr=%0d done=%0d want 4/1", n_wr, n_done); end
    tests++; if (n_bad !== 0) begin fails++; $display("FAIL st_pop_while_stalled: got %0d want 0", n_bad); end
    tests++; if (n_multi_en !== 0) begin fails++; $display("FAIL st_multi_en: got %0d want 0", n_multi_en); end
    tests++; if (lat <= 32) begin fails++; $display("FAIL st_latency_grew: got %0d want >32", lat); end
  endtask

  task automatic test_timeout();
    int lat;
    run_job(2, 3, 1, 20, 0, 1'b0, 1'b0, lat);
    tests++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL to_err_set: got %b want 1", err_timeout); end
    tests++; if (n_comp !== 20 || n_wr !== 0) begin fails++; $display("FAIL to_no_drain: got comp=%0d wr=%0d want 20/0", n_comp, n_wr); end
    tests++; if (n_done !== 1 || lat !== 27) begin fails++; $display("FAIL to_done: got done=%0d lat=%0d want 1/27", n_done, lat); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b want 1", err_timeout); end
    run_job(1, 1, 1, 50, 2, 1'b0, 1'b0, lat);
    tests++; if (err_timeout !== 1'b0 || n_wr !== 4) begin fails++; $display("FAIL to_cleared: got err=%b wr=%0d want 0/4", err_timeout, n_wr); end
  endtask

  task automatic test_edge_cfg();
    int lat;
    run_job(0, 4, 0, 200, 5, 1'b0, 1'b1, lat);
    repeat (20) @(posedge clk);
    #1;
    tests++; if (n_pop_f !== 0 || n_pop_i !== 4 || n_pop_p !== 0) begin fails++; $display("FAIL ec_pops: got f=%0d i=%0d p=%0d want 0/4/0", n_pop_f, n_pop_i, n_pop_p); end
    tests++; if (n_wr !== 4 || lat !== 15) begin fails++; $display("FAIL ec_one_pass: got wr=%0d lat=%0d want 4/15", n_wr, lat); end
    tests++; if (n_done !== 1 || busy !== 1'b0) begin fails++; $display("FAIL ec_single_job: got done=%0d busy=%b want 1/0", n_done, busy); end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_nominal();
    test_multi_pass();
    test_stalls();
    test_timeout();
    test_edge_cfg();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation still running at 2ms, required completion");
    $fatal(1);
  end

endmodule
